// File: rtl/rsa_pkg.sv
// Shared RSA-datapath definitions: the default operand width, the reducer FSM
// state type and the width of its bit counter.
package rsa_pkg;
  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(2 * WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } emod_state_t;
endpackage

// File: rtl/emod_red_if.sv
// Handshake and operand bundle between a multiply/reduce controller (master)
// and the modular-reduction stage (slave).
interface emod_red_if #(parameter int WIDTH = rsa_pkg::WIDTH);
  logic                 enable;
  logic [2*WIDTH-1:0]   x;
  logic [WIDTH-1:0]     n;
  logic [WIDTH-1:0]     r;
  logic [2*WIDTH-1:0]   q;
  logic                 err;
  logic                 ready;

  modport master (output enable, x, n, input r, q, err, ready);
  modport slave  (input enable, x, n, output r, q, err, ready);
endinterface

// File: rtl/emod_red_step.sv
// One restoring shift-subtract step: append the incoming dividend bit to the
// partial remainder and subtract the modulus when it fits.
module emod_red_step #(parameter int WIDTH = rsa_pkg::WIDTH) (
  input  logic [WIDTH-1:0] rem,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] rem_nxt,
  output logic             q_bit
);
  logic [WIDTH:0] t;

  assign t     = {rem, bit_in};
  assign q_bit = (t >= {1'b0, n});
  // The result is always below n, so wrap-around W-bit subtraction is exact.
  assign rem_nxt = q_bit ? (t[WIDTH-1:0] - n) : t[WIDTH-1:0];
endmodule

// File: rtl/emod_red.sv
// Sequential x mod n reducer, one quotient bit per clock; result and ready
// are held in DONE until reset.
module emod_red #(parameter int WIDTH = rsa_pkg::WIDTH) (
  input logic      clock,
  input logic      reset,
  emod_red_if.slave bus
);
  import rsa_pkg::*;

  localparam int            CW   = $clog2(2 * WIDTH);
  localparam logic [CW-1:0] LAST = CW'(2 * WIDTH - 1);

  emod_state_t        state, state_nxt;
  logic [2*WIDTH-1:0] div;
  logic [WIDTH-1:0]   nreg, rem, rem_nxt;
  logic [CW-1:0]      cnt;
  logic               qbit;
  logic [WIDTH-1:0]   r_reg;
  logic [2*WIDTH-1:0] q_reg;
  logic               err_reg, ready_reg;

  emod_red_step #(.WIDTH(WIDTH)) u_step (
    .rem     (rem),
    .bit_in  (div[2*WIDTH-1]),
    .n       (nreg),
    .rem_nxt (rem_nxt),
    .q_bit   (qbit)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.enable) state_nxt = (bus.n == '0) ? DONE : RUN;
      RUN:  if (cnt == LAST) state_nxt = DONE;
      DONE: state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // The dividend register shifts quotient bits in at the bottom as the
  // dividend bits leave the top, so it holds the quotient after the last step.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div       <= '0;
      nreg      <= '0;
      rem       <= '0;
      cnt       <= '0;
      r_reg     <= '0;
      q_reg     <= '0;
      err_reg   <= 1'b0;
      ready_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.enable) begin
            if (bus.n != '0) begin
              div  <= bus.x;
              nreg <= bus.n;
              rem  <= '0;
              cnt  <= '0;
            end else begin
              err_reg   <= 1'b1;
              ready_reg <= 1'b1;
            end
          end
        end
        RUN: begin
          rem <= rem_nxt;
          div <= {div[2*WIDTH-2:0], qbit};
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            r_reg     <= rem_nxt;
            q_reg     <= {div[2*WIDTH-2:0], qbit};
            ready_reg <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.r     = r_reg;
  assign bus.q     = q_reg;
  assign bus.err   = err_reg;
  assign bus.ready = ready_reg;
endmodule

// File: tb/tb_emod_red.sv
// Directed bench for emod_red: expected remainder/quotient/error are queued
// when an operation is launched and compared when ready rises.
module tb_emod_red;
  localparam int W = 8;

  typedef struct {
    logic [W-1:0]   r;
    logic [2*W-1:0] q;
    logic           err;
    int             lat;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   errors  = 0;
  exp_t sb[$];

  emod_red_if #(.WIDTH(W)) bus ();

  emod_red #(.WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Launch one operation, wait for ready, and compare against the queued result.
  task automatic run_op(input string tag, input logic [2*W-1:0] xv, input logic [W-1:0] nv,
                        input bit perturb, output exp_t got);
    exp_t e;
    int   edges;
    @(negedge clock);
    bus.x = xv;
    bus.n = nv;
    bus.enable = 1'b1;
    if (nv == 0) begin
      e.r = '0; e.q = '0; e.err = 1'b1; e.lat = 1;
    end else begin
      e.r = W'(xv % nv); e.q = xv / nv; e.err = 1'b0; e.lat = 2 * W + 1;
    end
    sb.push_back(e);
    @(posedge clock); #1;
    bus.enable = 1'b0;
    edges = 1;
    while (!bus.ready && edges < 40) begin
      if (edges == 5) begin
        check({tag, "_run_r0"}, 32'(bus.r), 32'd0);
        check({tag, "_run_q0"}, 32'(bus.q), 32'd0);
      end
      if (perturb) begin
        bus.x = 16'($urandom);
        bus.n = 8'($urandom);
      end
      @(posedge clock); #1;
      edges++;
    end
    got = sb.pop_front();
    check({tag, "_ready"}, 32'(bus.ready), 32'd1);
    check({tag, "_latency"}, 32'(edges), 32'(got.lat));
    check({tag, "_r"}, 32'(bus.r), 32'(got.r));
    check({tag, "_q"}, 32'(bus.q), 32'(got.q));
    check({tag, "_err"}, 32'(bus.err), 32'(got.err));
  endtask

  // Outputs must not move in DONE while enable and operands toggle.
  task automatic hold_check(input string tag, input exp_t e);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      bus.enable = 1'b1;
      bus.x = 16'($urandom);
      bus.n = 8'($urandom);
      @(posedge clock); #1;
      check({tag, "_hold_r"}, 32'(bus.r), 32'(e.r));
      check({tag, "_hold_q"}, 32'(bus.q), 32'(e.q));
      check({tag, "_hold_rdy"}, 32'(bus.ready), 32'd1);
    end
    bus.enable = 1'b0;
  endtask

  // Reset is applied between clock edges so a synchronous reset would be seen late.
  task automatic reset_check(input string tag);
    @(negedge clock); #2;
    reset = 1'b1;
    #1;
    check({tag, "_rst_ready"}, 32'(bus.ready), 32'd0);
    check({tag, "_rst_r"}, 32'(bus.r), 32'd0);
    check({tag, "_rst_q"}, 32'(bus.q), 32'd0);
    check({tag, "_rst_err"}, 32'(bus.err), 32'd0);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    exp_t got;
    bus.enable = 1'b0;
    bus.x = '0;
    bus.n = '0;
    #12;
    check("por_ready", 32'(bus.ready), 32'd0);
    check("por_r", 32'(bus.r), 32'd0);
    check("por_q", 32'(bus.q), 32'd0);
    check("por_err", 32'(bus.err), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    run_op("op1", 16'd3825, 8'd251, 1'b0, got);
    hold_check("op1", got);
    reset_check("op1");

    run_op("op2", 16'd38325, 8'd97, 1'b0, got);
    reset_check("op2");

    run_op("max", 16'd65535, 8'd255, 1'b0, got);
    reset_check("max");
    run_op("zero_x", 16'd0, 8'd7, 1'b0, got);
    reset_check("zero_x");
    run_op("n_one", 16'd1234, 8'd1, 1'b0, got);
    reset_check("n_one");

    run_op("n_zero", 16'd500, 8'd0, 1'b0, got);
    hold_check("n_zero", got);
    reset_check("n_zero");

    // Abort an operation five edges into RUN; no partial result may surface.
    @(negedge clock);
    bus.x = 16'd500;
    bus.n = 8'd7;
    bus.enable = 1'b1;
    @(posedge clock); #1;
    bus.enable = 1'b0;
    repeat (5) @(posedge clock);
    reset_check("midrun");
    repeat (20) @(posedge clock);
    #1;
    check("midrun_no_result", 32'(bus.ready), 32'd0);
    run_op("after_abort", 16'd1000, 8'd13, 1'b0, got);
    reset_check("after_abort");

    // Reset dominates a simultaneous enable.
    @(negedge clock);
    reset = 1'b1;
    bus.x = 16'd77;
    bus.n = 8'd0;
    bus.enable = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("rst_en_ready", 32'(bus.ready), 32'd0);
    check("rst_en_err", 32'(bus.err), 32'd0);
    @(negedge clock);
    bus.enable = 1'b0;
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_en_idle", 32'(bus.ready), 32'd0);

    // Product of a=15, b=255 from the multiplier, operands disturbed during RUN.
    run_op("chain", 16'(15 * 255), 8'd251, 1'b1, got);
    reset_check("chain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/emod_red.md
# emod_red

Sequential modular-reduction stage directly downstream of the `emul_sql` multiplier in the RSA datapath. It consumes the 2·WIDTH-bit product `x` and reduces it modulo a WIDTH-bit modulus `n`, one bit per clock, using restoring shift-subtract. It returns the remainder, the quotient and an error flag, and uses the same `enable`/`ready`/`reset` handshake as the multiplier, so a controller can chain multiply → reduce in modular exponentiation.

## Interface
- `WIDTH`, default 8: modulus and remainder width; product and quotient width is 2·WIDTH.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high; clears all state and outputs.
- `enable`  in  1  start request; sampled only in IDLE.
- `x`  in  2·WIDTH  dividend (product from `emul_sql`); must be stable when `enable` is sampled.
- `n`  in  WIDTH  modulus; must be stable when `enable` is sampled.
- `r`  out  WIDTH  remainder, x mod n.
- `q`  out  2·WIDTH  quotient, x / n.
- `err`  out  1  high when n == 0.
- `ready`  out  1  result valid; sticky until reset.

## Operation
- States: IDLE, RUN, DONE. Reset forces IDLE with `r`=0, `q`=0, `err`=0, `ready`=0, internal remainder=0 and bit counter=0.
- **IDLE, `enable`=0:** stay in IDLE.
- **IDLE, `enable`=1, `n`≠0:**
  - Latch `x` into the dividend shift register and `n` into the modulus register.
  - Clear the remainder and the counter.
  - Go to RUN.
- **IDLE, `enable`=1, `n`=0:** go to DONE with `err`=1, `r`=0, `q`=0.
- **RUN, each edge:**
  - Form t = {rem, dividend MSB}, WIDTH+1 bits wide.
  - If t ≥ n: rem = t − n, shift 1 into `q`. Otherwise rem = t[WIDTH-1:0], shift 0 into `q`.
  - Shift the dividend left by 1 and increment the counter.
- **RUN exit:** after the edge with counter = 2·WIDTH−1, go to DONE, drive `r` = rem, set `ready`=1.
- **DONE:** hold `r`, `q`, `err` and `ready`=1 regardless of `enable`, `x` or `n`. Only `reset` leaves DONE.
- Width rule: rem < n ≤ 2^WIDTH−1 at all times, so t fits in WIDTH+1 bits and the subtraction never underflows.
- Input changes on `x`/`n` during RUN or DONE are ignored, because the operands are latched.
- Outputs `r`/`q` are 0 in IDLE and RUN. They are valid only when `ready`=1.

## Timing
- Normal latency: `enable` sampled at edge E0 → `ready`=1 visible after edge E0 + 2·WIDTH + 1 (17 edges for WIDTH=8).
- Error latency: `ready`=1 and `err`=1 visible after edge E0 + 1.
- Reset mid-RUN: outputs go to 0 immediately (asynchronously), with no partial result. After reset releases, a new `enable` starts a fresh operation.
- `reset` and `enable` high together: reset wins.
- `ready` falls only on `reset`. This matches the multiplier, so a shared controller can clear both with one reset.

## Structure
- Shared package `rsa_pkg`:
  - `WIDTH` default constant (8).
  - State typedef `emod_state_t` {IDLE, RUN, DONE}.
  - Counter width constant $clog2(2·WIDTH).
- Sub-module `emod_red_step`: combinational conditional-subtract cell. Inputs: rem, incoming bit, n. Outputs: next rem, quotient bit. It is instantiated once; the top holds the FSM, counter and registers.

## Test plan
- x=3825 (15×255), n=251 → after 17 edges `ready`=1, `r`=60, `q`=15, `err`=0.
- x=38325 (175×219), n=97, run after reset between ops → `r`=10, `q`=395. `ready` stays 1 until reset, then drops immediately.
- Boundaries:
  - x=65535, n=255 → `r`=0, `q`=257.
  - x=0, n=7 → `r`=0, `q`=0.
  - x=1234, n=1 → `r`=0, `q`=1234.
- n=0, x=500 → `ready`=1 after 1 edge, `err`=1, `r`=0, `q`=0.
- Reset asserted 5 edges into RUN → `ready`/`r`/`q` read 0 immediately. A new op x=1000, n=13 then yields `r`=12, `q`=76.
- Chained with `emul_sql` (a=15, b=255) → feed `x` on multiplier `ready`, n=251 → `r`=60. Change `x`/`n` during RUN → result unaffected.
